data_sync_rx: RTL and testbench



---
 rtl/data_sync_rx_pkg.sv | 17 +
 rtl/data_sync_rx_bit_sync.sv | 32 +++
 rtl/data_sync_rx.sv | 98 +++++++++
 tb/tb_data_sync_rx.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_sync_rx_pkg.sv
// Definitions shared by both ends of the toggle-handshake CDC transfer:
// FSM encoding and the legal synchronizer depth range.
package data_sync_rx_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_e;

    localparam int unsigned NUM_STAGES_MIN = 2;
    localparam int unsigned NUM_STAGES_MAX = 4;

    function automatic logic stages_legal(input int unsigned n);
        return (n >= NUM_STAGES_MIN) && (n <= NUM_STAGES_MAX);
    endfunction

endpackage

// File: rtl/data_sync_rx_bit_sync.sv
// Single-bit multi-flop synchronizer; the source side reuses it for the ack toggle.
module data_sync_rx_bit_sync #(
    parameter int unsigned NUM_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [NUM_STAGES-1:0] sync_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) sync_q[gi] <= 1'b0;
                    else         sync_q[gi] <= d_i;
                end
            end else begin : g_rest
                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) sync_q[gi] <= 1'b0;
                    else         sync_q[gi] <= sync_q[gi-1];
                end
            end
        end
    endgenerate

    assign q_o = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/data_sync_rx.sv
// Destination end of the toggle-handshake CDC: synchronizes the request toggle,
// captures the held bus once, hands it out with VALID/READY and returns an ack toggle.
module data_sync_rx
    import data_sync_rx_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 2,
    parameter int unsigned BUS_WIDTH  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [BUS_WIDTH-1:0] unsync_bus_i,
    input  logic                 req_tog_i,
    output logic [BUS_WIDTH-1:0] sync_bus_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 enable_pulse_o,
    output logic                 ack_tog_o,
    output logic                 overrun_err_o
);

    generate
        if (!stages_legal(NUM_STAGES)) begin : g_bad_depth
            $error("data_sync_rx: NUM_STAGES out of legal range");
        end
    endgenerate

    logic                 req_sync;
    logic                 prev_q;
    logic                 req_edge;
    state_e               state_q, state_d;
    logic [BUS_WIDTH-1:0] bus_q, bus_d;
    logic                 en_q, en_d;
    logic                 ack_q, ack_d;
    logic                 ovr_q, ovr_d;

    data_sync_rx_bit_sync #(
        .NUM_STAGES(NUM_STAGES)
    ) u_req_sync (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   (req_tog_i),
        .q_o   (req_sync)
    );

    assign req_edge = req_sync ^ prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q  <= 1'b0;
            state_q <= IDLE;
            bus_q   <= '0;
            en_q    <= 1'b0;
            ack_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            prev_q  <= req_sync;
            state_q <= state_d;
            bus_q   <= bus_d;
            en_q    <= en_d;
            ack_q   <= ack_d;
            ovr_q   <= ovr_d;
        end
    end

    // The bus is only looked at on the capture edge; an edge while a word is
    // still pending is a source protocol violation and the new word is lost.
    always_comb begin
        state_d = state_q;
        bus_d   = bus_q;
        en_d    = 1'b0;
        ack_d   = ack_q;
        ovr_d   = ovr_q;
        case (state_q)
            IDLE: begin
                if (req_edge) begin
                    bus_d   = unsync_bus_i;
                    en_d    = 1'b1;
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (req_edge) ovr_d = 1'b1;
                if (ready_i) begin
                    ack_d   = ~ack_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sync_bus_o     = bus_q;
    assign valid_o        = (state_q == PENDING);
    assign enable_pulse_o = en_q;
    assign ack_tog_o      = ack_q;
    assign overrun_err_o  = ovr_q;

endmodule

// File: tb/tb_data_sync_rx.sv
// Bench for data_sync_rx: three depths (2,3,4) driven in parallel, checked
// every cycle against a request-history model plus directed literal checks.
module tb_data_sync_rx;

    localparam int ND = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] bus;
    logic       req;
    logic       ready;

    logic [7:0] sync_bus_w [ND];
    logic       valid_w    [ND];
    logic       en_w       [ND];
    logic       ack_w      [ND];
    logic       ovr_w      [ND];

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < ND; gi++) begin : g_dut
            data_sync_rx #(
                .NUM_STAGES(gi + 2),
                .BUS_WIDTH (8)
            ) u_dut (
                .clk_i         (clk),
                .rst_ni        (rst_n),
                .unsync_bus_i  (bus),
                .req_tog_i     (req),
                .sync_bus_o    (sync_bus_w[gi]),
                .valid_o       (valid_w[gi]),
                .ready_i       (ready),
                .enable_pulse_o(en_w[gi]),
                .ack_tog_o     (ack_w[gi]),
                .overrun_err_o (ovr_w[gi])
            );
        end
    endgenerate

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        else passes++;
    endtask

    // ---------------- behavioural model ----------------
    // hist[k-1] is the REQ_TOG level sampled at rising edge k since reset.
    // A depth-NS receiver sees a request edge at edge n when the levels
    // sampled NS and NS+1 edges earlier differ.
    logic       hist [$];
    logic       m_pend [ND];
    logic [7:0] m_word [ND];
    logic       m_en   [ND];
    logic       m_ack  [ND];
    logic       m_ovr  [ND];
    int         mdl_n;
    logic       mdl_edge;
    int         en_cnt0 = 0;

    function automatic logic hist_at(input int k);
        if (k >= 1 && k <= hist.size()) return hist[k-1];
        return 1'b0;
    endfunction

    initial begin
        for (int d = 0; d < ND; d++) begin
            m_pend[d] = 0; m_word[d] = 0; m_en[d] = 0; m_ack[d] = 0; m_ovr[d] = 0;
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            hist.delete();
            for (int d = 0; d < ND; d++) begin
                m_pend[d] = 0; m_word[d] = 0; m_en[d] = 0; m_ack[d] = 0; m_ovr[d] = 0;
            end
        end else begin
            mdl_n = hist.size() + 1;
            for (int d = 0; d < ND; d++) begin
                mdl_edge = hist_at(mdl_n - (d + 2)) ^ hist_at(mdl_n - (d + 3));
                m_en[d] = 0;
                if (!m_pend[d]) begin
                    if (mdl_edge) begin
                        m_pend[d] = 1; m_word[d] = bus; m_en[d] = 1;
                    end
                end else begin
                    if (mdl_edge) m_ovr[d] = 1;
                    if (ready) begin
                        m_pend[d] = 0; m_ack[d] = ~m_ack[d];
                    end
                end
            end
            hist.push_back(req);
        end
        #1;
        if (rst_n) begin
            if (en_w[0]) en_cnt0++;
            for (int d = 0; d < ND; d++) begin
                chk($sformatf("mdl_bus[%0d]", d),   {24'd0, sync_bus_w[d]}, {24'd0, m_word[d]});
                chk($sformatf("mdl_valid[%0d]", d), {31'd0, valid_w[d]},    {31'd0, m_pend[d]});
                chk($sformatf("mdl_en[%0d]", d),    {31'd0, en_w[d]},       {31'd0, m_en[d]});
                chk($sformatf("mdl_ack[%0d]", d),   {31'd0, ack_w[d]},      {31'd0, m_ack[d]});
                chk($sformatf("mdl_ovr[%0d]", d),   {31'd0, ovr_w[d]},      {31'd0, m_ovr[d]});
            end
        end
    end

    // ---------------- bounded waits ----------------
    function automatic logic all_valid();
        logic r = 1'b1;
        for (int d = 0; d < ND; d++) r &= valid_w[d];
        return r;
    endfunction

    function automatic logic all_acked();
        logic r = 1'b1;
        for (int d = 0; d < ND; d++) r &= (ack_w[d] == req);
        return r;
    endfunction

    task automatic wait_all_valid(input string nm);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (all_valid()) return;
        end
        chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_valid0(input string nm);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid_w[0]) return;
        end
        chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_all_acked(input string nm);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (all_acked()) return;
        end
        chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic chk_all_zero(input string nm);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("%s_bus[%0d]", nm, d),   {24'd0, sync_bus_w[d]}, 32'd0);
            chk($sformatf("%s_valid[%0d]", nm, d), {31'd0, valid_w[d]},    32'd0);
            chk($sformatf("%s_en[%0d]", nm, d),    {31'd0, en_w[d]},       32'd0);
            chk($sformatf("%s_ack[%0d]", nm, d),   {31'd0, ack_w[d]},      32'd0);
            chk($sformatf("%s_ovr[%0d]", nm, d),   {31'd0, ovr_w[d]},      32'd0);
        end
    endtask

    // ---------------- directed stimulus ----------------
    int   lat [ND];
    logic ack_before;
    int   en_before;

    initial begin
        rst_n = 1'b0; req = 1'b0; ready = 1'b0; bus = 8'h00;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // single transfer, consumer ready
        @(negedge clk);
        bus = 8'hA5; ready = 1'b1; req = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("single_valid_e3", {31'd0, valid_w[0]}, 32'd1);
        chk("single_en_e3",    {31'd0, en_w[0]},    32'd1);
        chk("single_bus_e3",   {24'd0, sync_bus_w[0]}, 32'hA5);
        chk("single_ack_e3",   {31'd0, ack_w[0]},   32'd0);
        @(posedge clk);
        #2;
        chk("single_valid_e4", {31'd0, valid_w[0]}, 32'd0);
        chk("single_ack_e4",   {31'd0, ack_w[0]},   32'd1);
        chk("single_en_e4",    {31'd0, en_w[0]},    32'd0);
        wait_all_acked("single");
        $display("transaction single: bus=a5 ack=%0d", ack_w[0]);

        // backpressure
        @(negedge clk);
        ready = 1'b0; bus = 8'h3C; req = ~req;
        wait_all_valid("bp");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid_hold", {31'd0, valid_w[0]}, 32'd1);
            chk("bp_bus_hold",   {24'd0, sync_bus_w[0]}, 32'h3C);
            chk("bp_no_repulse", {31'd0, en_w[0]}, 32'd0);
        end
        ready = 1'b1;
        @(posedge clk);
        #2;
        chk("bp_ack_flip",  {31'd0, ack_w[0]},   {31'd0, req});
        chk("bp_valid_low", {31'd0, valid_w[0]}, 32'd0);
        wait_all_acked("bp");
        $display("transaction backpressure: bus=3c ack=%0d", ack_w[0]);

        // back-to-back words
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            ack_before = ack_w[0];
            bus = 8'(k); req = ~req;
            wait_valid0("b2b");
            chk($sformatf("b2b_word%0d", k), {24'd0, sync_bus_w[0]}, k);
            wait_all_acked("b2b");
            chk($sformatf("b2b_ack%0d", k), {31'd0, ack_w[0]}, {31'd0, ~ack_before});
            $display("transaction b2b: word=%02h ack=%0d", sync_bus_w[0], ack_w[0]);
        end
        for (int d = 0; d < ND; d++)
            chk($sformatf("b2b_ovr[%0d]", d), {31'd0, ovr_w[d]}, 32'd0);

        // overrun
        @(negedge clk);
        en_before = en_cnt0;
        ready = 1'b0; bus = 8'h11; req = ~req;
        wait_all_valid("ovr");
        bus = 8'h22; req = ~req;
        repeat (8) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("ovr_flag[%0d]", d),  {31'd0, ovr_w[d]},   32'd1);
            chk($sformatf("ovr_bus[%0d]", d),   {24'd0, sync_bus_w[d]}, 32'h11);
            chk($sformatf("ovr_valid[%0d]", d), {31'd0, valid_w[d]}, 32'd1);
        end
        chk("ovr_one_pulse", en_cnt0 - en_before, 32'd1);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("ovr_sticky[%0d]", d), {31'd0, ovr_w[d]},   32'd1);
            chk($sformatf("ovr_drain[%0d]", d),  {31'd0, valid_w[d]}, 32'd0);
        end
        $display("transaction overrun: held=11 ovr=%0d", ovr_w[0]);

        // asynchronous reset while a word is pending
        @(negedge clk);
        bus = 8'h55; req = ~req;
        wait_valid0("mrst");
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1 chk_all_zero("mrst");
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            for (int d = 0; d < ND; d++)
                chk($sformatf("idle_valid[%0d]", d), {31'd0, valid_w[d]}, 32'd0);
        end
        $display("transaction reset: outputs cleared, idle 20 cycles");

        // latency per depth
        @(negedge clk);
        ready = 1'b1; bus = 8'h77; req = 1'b1;
        for (int d = 0; d < ND; d++) lat[d] = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < ND; d++)
                if (lat[d] == 0 && valid_w[d]) lat[d] = c;
        end
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("latency_ns%0d", d + 2), lat[d], d + 3);
            $display("transaction depth: ns=%0d valid_edge=%0d", d + 2, lat[d]);
        end
        wait_all_acked("depth");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
